// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-bank port arbiter.
package regfile_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        WR_PRIO = 1'b0,
        RD_PRIO = 1'b1
    } arb_state_e;

endpackage

// File: rtl/regfile_port_arbiter_starve_counter.sv
// Saturating count of stalled read cycles; flags when the next value hits the limit.
module starve_counter
    import regfile_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic limit_d
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        limit_d = (cnt_d == CNT_W'(LIMIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Serializes writeback writes and decode reads onto a bank that cannot read and write on one edge.
module regfile_port_arbiter #(
    parameter int unsigned ADDR_W       = regfile_pkg::ADDR_W,
    parameter int unsigned DATA_W       = regfile_pkg::DATA_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2,
    output logic [ADDR_W-1:0] rb_read1,
    output logic [ADDR_W-1:0] rb_read2,
    output logic [ADDR_W-1:0] rb_write_port,
    output logic [DATA_W-1:0] rb_bus_c,
    output logic              rb_reg_write,
    input  logic [DATA_W-1:0] rb_bus_a,
    input  logic [DATA_W-1:0] rb_bus_b
);
    import regfile_pkg::*;

    arb_state_e state_q;
    arb_state_e state_d;
    logic       rsp_valid_q;
    logic       rsp_valid_d;
    logic       real_wr;
    logic       rd_gnt;
    logic       wr_gnt;
    logic       stall_inc;
    logic       limit_d;

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (stall_inc),
        .clr     (rd_gnt),
        .limit_d (limit_d)
    );

    // Grant: write wins a conflict unless reads have been starved to the limit.
    always_comb begin
        real_wr   = wb_valid && (wb_addr != ADDR_W'(REG_ZERO));
        rd_gnt    = rst_n && rd_valid && (!real_wr || (state_q == RD_PRIO));
        wr_gnt    = rst_n && real_wr && !(rd_valid && (state_q == RD_PRIO));
        stall_inc = rst_n && rd_valid && !rd_gnt;

        wb_ready     = rst_n && wb_valid && (!real_wr || wr_gnt);
        rd_ready     = rd_gnt;
        rb_reg_write = wr_gnt;

        rb_write_port = rst_n ? wb_addr  : '0;
        rb_bus_c      = rst_n ? wb_data  : '0;
        rb_read1      = rst_n ? rd_addr1 : '0;
        rb_read2      = rst_n ? rd_addr2 : '0;

        rsp_valid = rsp_valid_q;
        rsp_data1 = rsp_valid_q ? rb_bus_a : '0;
        rsp_data2 = rsp_valid_q ? rb_bus_b : '0;

        rsp_valid_d = rd_gnt;
        state_d     = state_q;
        if (limit_d) begin
            state_d = RD_PRIO;
        end else if (rd_gnt) begin
            state_d = WR_PRIO;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WR_PRIO;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Randomized scoreboard bench for regfile_port_arbiter with a behavioural register bank.
module tb_regfile_port_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, wb_ready, rd_valid, rd_ready, rsp_valid, rb_reg_write;
    logic [4:0]  wb_addr, rd_addr1, rd_addr2, rb_read1, rb_read2, rb_write_port;
    logic [31:0] wb_data, rsp_data1, rsp_data2, rb_bus_c, rb_bus_a, rb_bus_b;

    regfile_port_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rsp_valid(rsp_valid), .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
        .rb_read1(rb_read1), .rb_read2(rb_read2), .rb_write_port(rb_write_port),
        .rb_bus_c(rb_bus_c), .rb_reg_write(rb_reg_write),
        .rb_bus_a(rb_bus_a), .rb_bus_b(rb_bus_b)
    );

    always #5 clk = ~clk;

    // Register bank: a write edge suppresses the registered read.
    logic [31:0] bank [32];
    always @(posedge clk) begin
        if (rb_reg_write) begin
            bank[rb_write_port] <= rb_bus_c;
        end else begin
            rb_bus_a <= (rb_read1 == 5'd0) ? 32'd0 : bank[rb_read1];
            rb_bus_b <= (rb_read2 == 5'd0) ? 32'd0 : bank[rb_read2];
        end
    end

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        int          tag;
    } exp_t;

    exp_t        q[$];
    logic [31:0] refm [32];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          stall = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : refm[a];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: arbitration rules, register contents, expected responses.
    always @(negedge clk) begin
        logic real_wr, exp_rd, exp_wr;
        exp_t e;
        if (!rst_n) begin
            stall = 0;
            chk("rst_wb_ready", 32'(wb_ready), 0);
            chk("rst_rd_ready", 32'(rd_ready), 0);
            chk("rst_reg_write", 32'(rb_reg_write), 0);
            chk("rst_rb_read1", 32'(rb_read1), 0);
            chk("rst_rb_bus_c", rb_bus_c, 0);
        end else begin
            real_wr = wb_valid && (wb_addr != 5'd0);
            exp_rd  = rd_valid && (!real_wr || stall == int'(LIMIT));
            exp_wr  = wb_valid && ((wb_addr == 5'd0) || !(rd_valid && stall == int'(LIMIT)));
            chk("wb_ready", 32'(wb_ready), 32'(exp_wr));
            chk("rd_ready", 32'(rd_ready), 32'(exp_rd));
            chk("reg_write", 32'(rb_reg_write), 32'(real_wr && exp_wr));
            chk("rb_read1", 32'(rb_read1), 32'(rd_addr1));
            chk("rb_read2", 32'(rb_read2), 32'(rd_addr2));
            if (real_wr && exp_wr) begin
                chk("rb_write_port", 32'(rb_write_port), 32'(wb_addr));
                chk("rb_bus_c", rb_bus_c, wb_data);
            end
            if (rd_valid && rd_ready) begin
                e.d1 = ref_rd(rd_addr1);
                e.d2 = ref_rd(rd_addr2);
                e.tag = cyc;
                q.push_back(e);
            end
            if (wb_valid && wb_ready && wb_addr != 5'd0) refm[wb_addr] = wb_data;
            if (exp_rd) stall = 0;
            else if (rd_valid && stall < 15) stall = stall + 1;
        end
    end

    // Monitor: every response pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                e = q.pop_front();
                chk("rsp_latency", 32'(cyc), 32'(e.tag + 1));
                chk("rsp_data1", rsp_data1, e.d1);
                chk("rsp_data2", rsp_data2, e.d2);
            end
        end else begin
            chk("rsp_idle_zero", rsp_data1 | rsp_data2, 0);
            if (q.size() > 0 && q[0].tag < cyc) begin
                chk("rsp_missing", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    // Present both requests and hold each until its handshake completes.
    task automatic xfer(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                        input logic rv, input logic [4:0] a1, input logic [4:0] a2);
        logic wacc, racc;
        wb_valid = wv; wb_addr = wa; wb_data = wd;
        rd_valid = rv; rd_addr1 = a1; rd_addr2 = a2;
        for (int k = 0; k < 40 && (wb_valid || rd_valid); k++) begin
            @(negedge clk);
            wacc = wb_valid && wb_ready;
            racc = rd_valid && rd_ready;
            @(posedge clk); #1;
            if (wacc) wb_valid = 1'b0;
            if (racc) rd_valid = 1'b0;
        end
        if (wb_valid || rd_valid) begin
            chk("xfer_timeout", 32'({wb_valid, rd_valid}), 0);
            wb_valid = 1'b0; rd_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic wacc, racc;
        int   n;
        for (int i = 0; i < 32; i++) begin bank[i] = 0; refm[i] = 0; end
        rst_n = 1'b0; wb_valid = 0; rd_valid = 0;
        wb_addr = 0; wb_data = 0; rd_addr1 = 0; rd_addr2 = 0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;

        xfer(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        xfer(0, 0, 0, 1, 5'd5, 5'd0);
        xfer(1, 5'd3, 32'h11, 1, 5'd3, 5'd4);
        xfer(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 5'd1);
        for (int i = 1; i <= 4; i++) xfer(1, 5'(i), 32'(i), 0, 0, 0);
        for (int i = 1; i <= 4; i++) xfer(0, 0, 0, 1, 5'(i), 5'(5 - i));

        // Continuous real writes against a held read.
        rd_valid = 1; rd_addr1 = 5'd1; rd_addr2 = 5'd2;
        wb_valid = 1; wb_addr = 5'd9; wb_data = $urandom;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            wacc = wb_valid && wb_ready;
            racc = rd_valid && rd_ready;
            n++;
            if (racc) chk("starve_wb_blocked", 32'(wb_ready), 0);
            @(posedge clk); #1;
            if (wacc) begin wb_addr = 5'(1 + $urandom_range(30)); wb_data = $urandom; end
            if (racc) break;
        end
        rd_valid = 0;
        chk("starve_wait", 32'(n), 32'(LIMIT + 1));
        xfer(wb_valid, wb_addr, wb_data, 0, 0, 0);

        // Reset asserted inside a read-grant cycle.
        rd_valid = 1; rd_addr1 = 5'd5; rd_addr2 = 5'd3;
        #2 rst_n = 1'b0;
        #1 chk("rst_async_rd_ready", 32'(rd_ready), 0);
        repeat (2) @(posedge clk); #1;
        rd_valid = 0; rst_n = 1'b1;
        xfer(0, 0, 0, 1, 5'd5, 5'd3);

        for (int i = 0; i < 400; i++) begin
            if (!wb_valid && $urandom_range(2) == 0) begin
                wb_valid = 1;
                wb_addr = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(7));
                wb_data = $urandom;
            end
            if (!rd_valid && $urandom_range(1) == 0) begin
                rd_valid = 1;
                rd_addr1 = 5'($urandom_range(7));
                rd_addr2 = 5'($urandom_range(7));
            end
            @(negedge clk);
            wacc = wb_valid && wb_ready;
            racc = rd_valid && rd_ready;
            @(posedge clk); #1;
            if (wacc) wb_valid = 0;
            if (racc) rd_valid = 0;
        end
        xfer(wb_valid, wb_addr, wb_data, rd_valid, rd_addr1, rd_addr2);
        repeat (3) @(posedge clk); #1;
        chk("queue_empty", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Arbitrates the register bank between the writeback stage (one write per transaction) and the decode stage (two-operand read per transaction). The register bank cannot read and write in the same clock edge: a write edge suppresses its registered read. This block serializes the two requesters with a starvation-bounded priority scheme and drives the bank's port/address lines. It returns read data with a one-cycle response strobe and sits between the pipeline stages and the register bank.

## Interface
- ADDR_W, 5, register index width
- DATA_W, 32, register data width
- STARVE_LIMIT, 4, consecutive stalled read cycles before reads take priority over writes (range 1..15)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- wb_valid  in  1  writeback write request
- wb_ready  out  1  write accepted this cycle
- wb_addr  in  ADDR_W  destination register
- wb_data  in  DATA_W  write data
- rd_valid  in  1  decode read request
- rd_ready  out  1  read accepted this cycle
- rd_addr1, rd_addr2  in  ADDR_W  source registers
- rsp_valid  out  1  read data valid (one-cycle pulse)
- rsp_data1, rsp_data2  out  DATA_W  read results
- rb_read1, rb_read2  out  ADDR_W  to bank readPort1/readPort2
- rb_write_port  out  ADDR_W  to bank writePort
- rb_bus_c  out  DATA_W  to bank busC
- rb_reg_write  out  1  to bank regWrite
- rb_bus_a, rb_bus_b  in  DATA_W  from bank busA/busB

## Operation
- Transfer occurs when valid && ready. Requesters hold valid and payload stable until ready.
- A write with wb_addr==0 is a null write. wb_ready=1 immediately, rb_reg_write=0, and no bank cycle is consumed. A read may be granted in the same cycle.
- A real write (wb_addr!=0) and a read conflict. Only one is granted per cycle:
  - default: the write wins;
  - when starve_cnt==STARVE_LIMIT: the read wins and the write waits.
- starve_cnt (4 bits, saturating) behaviour:
  - increments each cycle with rd_valid && !rd_ready;
  - clears to 0 on a read grant;
  - holds otherwise.
- Arbitration states (registered): WR_PRIO (starve_cnt<STARVE_LIMIT) and RD_PRIO (starve_cnt==STARVE_LIMIT).
  - WR_PRIO→RD_PRIO when the counter reaches the limit.
  - RD_PRIO→WR_PRIO on a read grant.
- Bank drive (combinational from the grant):
  - rb_reg_write = real write granted; rb_write_port = wb_addr; rb_bus_c = wb_data.
  - rb_read1/rb_read2 = rd_addr1/rd_addr2 at all times.
  - When no real write is granted, rb_reg_write=0, so the bank samples reads.
- Response: rsp_valid is registered. It is 1 in the cycle after a read grant, else 0. rsp_data1/2 = rb_bus_a/rb_bus_b when rsp_valid, else 0.
- Reads of x0 return 0 (bank holds 0 in x0).
- No response backpressure. Decode must consume rsp in the pulse cycle.

## Timing
- Reset values: wb_ready=0, rd_ready=0, rsp_valid=0, rsp_data1/2=0, rb_reg_write=0, starve_cnt=0, state=WR_PRIO. All bank address/data outputs are 0.
- Reset is asynchronous on assertion and synchronous on release. A read granted in the cycle reset asserts produces no rsp_valid.
- Write latency: granted in cycle N; the bank is updated at the end of cycle N. A read granted in N+1 returns the new value.
- Read latency: granted in cycle N; rsp_valid in N+1. Back-to-back read grants give back-to-back rsp_valid pulses.
- Worst-case read wait with continuous real writes: STARVE_LIMIT cycles. Worst-case write wait: 1 cycle per read grant.
- Simultaneous null write and read: both are granted in the same cycle.

## Structure
- Shared package (regfile_pkg): ADDR_W, DATA_W defaults, the arb-state enum {WR_PRIO, RD_PRIO}, and the constant REG_ZERO=0.
- One natural sub-module: starve_counter, a saturating counter with inc/clear/limit-flag outputs. The rest is flat.

## Test plan
- Single write then read: write x5=0xDEADBEEF, then read x5/x0 → rsp_valid one cycle after grant; rsp_data1=0xDEADBEEF, rsp_data2=0.
- Simultaneous requests: wb x3=0x11 and rd x3/x4 both valid in cycle 0 → write granted cycle 0, read granted cycle 1, rsp_data1=0x11 in cycle 2.
- Starvation: wb_valid held with changing nonzero addrs and rd_valid held, STARVE_LIMIT=4 → rd_ready=1 on the 5th cycle, wb_ready=0 that cycle, counter back to 0.
- Null write: wb x0=0xFFFFFFFF with rd x0/x1 → both ready same cycle, rb_reg_write=0, rsp_data1=0.
- Reset mid-operation: assert rst_n=0 in the read-grant cycle → rsp_valid stays 0 and all outputs go to reset values immediately. After release the first read returns normally.
- Back-to-back reads: 4 consecutive read grants of x1..x4 preloaded with 1..4 → 4 consecutive rsp_valid pulses with rsp_data1=1,2,3,4.
